// File: rtl/systolic_seq_ctrl_if.sv
// Bus bundle for systolic_seq_ctrl: operand load port, job control/status and array operand buses.
// With SEQ_JOB_CNT_EN defined the bundle also carries the completed-job counter o_job_cnt.
interface systolic_seq_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              i_load_valid;
  logic              i_load_sel;
  logic [3:0]        i_load_addr;
  logic [DATA_W-1:0] i_load_data;
  logic              i_start;
  logic [2:0]        i_size;
  logic              o_busy;
  logic              o_done;
  logic              o_size_err;
  logic              o_arr_clear;
  logic              o_capture;
  logic [DATA_W-1:0] o_west_0;
  logic [DATA_W-1:0] o_west_1;
  logic [DATA_W-1:0] o_west_2;
  logic [DATA_W-1:0] o_west_3;
  logic [DATA_W-1:0] o_north_0;
  logic [DATA_W-1:0] o_north_1;
  logic [DATA_W-1:0] o_north_2;
  logic [DATA_W-1:0] o_north_3;
`ifdef SEQ_JOB_CNT_EN
  logic [15:0]       o_job_cnt;
`endif

  modport master (
`ifdef SEQ_JOB_CNT_EN
    input  o_job_cnt,
`endif
    output i_load_valid, i_load_sel, i_load_addr, i_load_data, i_start, i_size,
    input  o_busy, o_done, o_size_err, o_arr_clear, o_capture,
    input  o_west_0, o_west_1, o_west_2, o_west_3,
    input  o_north_0, o_north_1, o_north_2, o_north_3
  );

  modport slave (
`ifdef SEQ_JOB_CNT_EN
    output o_job_cnt,
`endif
    input  i_load_valid, i_load_sel, i_load_addr, i_load_data, i_start, i_size,
    output o_busy, o_done, o_size_err, o_arr_clear, o_capture,
    output o_west_0, o_west_1, o_west_2, o_west_3,
    output o_north_0, o_north_1, o_north_2, o_north_3
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic MAC array: buffers A/B, skews operands in, drains, captures.
// Optional macro SEQ_JOB_CNT_EN adds a 16-bit completed-job counter on the bus.
module systolic_seq_ctrl #(
  parameter int DATA_W   = 16,
  parameter int N        = 4,
  parameter int PIPE_LAT = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(N * N);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CAPT  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_sz;
  logic [2:0]        w_sz_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [DATA_W-1:0] r_buf_a [N*N];
  logic [DATA_W-1:0] r_buf_b [N*N];
  logic [DATA_W-1:0] r_west [N];
  logic [DATA_W-1:0] r_north [N];
  logic [DATA_W-1:0] w_west_nxt [N];
  logic [DATA_W-1:0] w_north_nxt [N];
  logic              r_busy;
  logic              r_done;
  logic              r_size_err;
  logic              r_arr_clear;
  logic              r_capture;
  logic              w_size_ok;
  logic [3:0]        w_feed_last_t;
  logic [3:0]        w_drain_len;

  assign w_size_ok     = (bus.i_size != 3'd0) && (bus.i_size <= 3'(N));
  assign w_feed_last_t = {r_sz, 1'b0} - 4'd2;
  assign w_drain_len   = {1'b0, r_sz} + 4'(PIPE_LAT) - 4'd1;

  // Next-state, phase counter and latched job size
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sz_nxt    = r_sz;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start && w_size_ok) begin
          w_state_nxt = ST_CLEAR;
          w_sz_nxt    = bus.i_size;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_FEED;
        w_cnt_nxt   = 4'd0;
      end
      ST_FEED: begin
        if (r_cnt == w_feed_last_t) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = (w_drain_len == 4'd0) ? ST_CAPT : ST_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == w_drain_len - 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_CAPT;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_CAPT: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Skewed operand selection for the upcoming cycle; the feed step t is the next counter value
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if ((w_state_nxt == ST_FEED) && (i < int'(w_sz_nxt)) && (int'(w_cnt_nxt) >= i) &&
          (int'(w_cnt_nxt) - i < int'(w_sz_nxt))) begin
        w_west_nxt[i]  = r_buf_a[AW'(i * N + int'(w_cnt_nxt) - i)];
        w_north_nxt[i] = r_buf_b[AW'((int'(w_cnt_nxt) - i) * N + i)];
      end else begin
        w_west_nxt[i]  = '0;
        w_north_nxt[i] = '0;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_sz        <= 3'd0;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_size_err  <= 1'b0;
      r_arr_clear <= 1'b0;
      r_capture   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_west[i]  <= '0;
        r_north[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_sz        <= w_sz_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_CAPT);
      r_capture   <= (w_state_nxt == ST_CAPT);
      r_arr_clear <= (w_state_nxt == ST_CLEAR);
      r_size_err  <= (r_state == ST_IDLE) && bus.i_start && !w_size_ok;
      for (int i = 0; i < N; i++) begin
        r_west[i]  <= w_west_nxt[i];
        r_north[i] <= w_north_nxt[i];
      end
    end
  end

  // Operand buffers: writable only while idle, deliberately kept out of reset
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == ST_IDLE) && bus.i_load_valid) begin
      if (bus.i_load_sel) begin
        r_buf_b[bus.i_load_addr] <= bus.i_load_data;
      end else begin
        r_buf_a[bus.i_load_addr] <= bus.i_load_data;
      end
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_size_err  = r_size_err;
  assign bus.o_arr_clear = r_arr_clear;
  assign bus.o_capture   = r_capture;
  assign bus.o_west_0    = r_west[0];
  assign bus.o_west_1    = r_west[1];
  assign bus.o_west_2    = r_west[2];
  assign bus.o_west_3    = r_west[3];
  assign bus.o_north_0   = r_north[0];
  assign bus.o_north_1   = r_north[1];
  assign bus.o_north_2   = r_north[2];
  assign bus.o_north_3   = r_north[3];

`ifdef SEQ_JOB_CNT_EN
  logic [15:0] r_job_cnt;

  // Completed-job counter, bumped the cycle after each done pulse; aborted jobs never reach done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_job_cnt <= 16'd0;
    end else if (r_done) begin
      r_job_cnt <= r_job_cnt + 16'd1;
    end else begin
      r_job_cnt <= r_job_cnt;
    end
  end

  assign bus.o_job_cnt = r_job_cnt;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: job-timeline model checked every cycle, plus a 4x4 MAC array model fed by the DUT.
module tb_systolic_seq_ctrl;
  localparam int DW = 16;
  localparam int PL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  systolic_seq_ctrl_if #(.DATA_W(DW)) bus ();

  systolic_seq_ctrl #(.DATA_W(DW), .N(4), .PIPE_LAT(PL)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] west_v [4];
  logic [15:0] north_v [4];
  assign west_v[0]  = bus.o_west_0;
  assign west_v[1]  = bus.o_west_1;
  assign west_v[2]  = bus.o_west_2;
  assign west_v[3]  = bus.o_west_3;
  assign north_v[0] = bus.o_north_0;
  assign north_v[1] = bus.o_north_1;
  assign north_v[2] = bus.o_north_2;
  assign north_v[3] = bus.o_north_3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- job timeline model ----------------
  logic [15:0] m_a [16];
  logic [15:0] m_b [16];
  logic        m_valid  = 1'b0;
  logic        m_active = 1'b0;
  logic        m_serr   = 1'b0;
  int          m_k      = 0;
  int          m_sz     = 0;
  logic [15:0] m_jc     = 16'd0;

  // cycle index (CLEAR = 1) at which capture/done is high
  function automatic int capt_k(int sz);
    return 1 + (2 * sz - 1) + (sz - 1 + PL) + 1;
  endfunction

  function automatic logic [15:0] exp_west(int i);
    int t;
    if (!m_active || m_k < 2 || m_k > 2 * m_sz) return 16'd0;
    t = m_k - 2;
    if (i < m_sz && t >= i && t - i < m_sz) return m_a[i * 4 + t - i];
    return 16'd0;
  endfunction

  function automatic logic [15:0] exp_north(int j);
    int t;
    if (!m_active || m_k < 2 || m_k > 2 * m_sz) return 16'd0;
    t = m_k - 2;
    if (j < m_sz && t >= j && t - j < m_sz) return m_b[(t - j) * 4 + j];
    return 16'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_k      <= 0;
      m_serr   <= 1'b0;
      m_jc     <= 16'd0;
    end else begin
      m_serr <= 1'b0;
      if (m_active && m_k == capt_k(m_sz)) m_jc <= m_jc + 16'd1;
      if (!m_active) begin
        if (bus.i_load_valid) begin
          if (bus.i_load_sel) m_b[bus.i_load_addr] <= bus.i_load_data;
          else m_a[bus.i_load_addr] <= bus.i_load_data;
        end
        if (bus.i_start) begin
          if (bus.i_size >= 3'd1 && bus.i_size <= 3'd4) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_sz     <= int'(bus.i_size);
          end else begin
            m_serr <= 1'b1;
          end
        end
      end else if (m_k == capt_k(m_sz)) begin
        m_active <= 1'b0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'd0, bus.o_busy}, {31'd0, m_active});
      chk("done", {31'd0, bus.o_done}, {31'd0, m_active && m_k == capt_k(m_sz)});
      chk("capture", {31'd0, bus.o_capture}, {31'd0, m_active && m_k == capt_k(m_sz)});
      chk("arr_clear", {31'd0, bus.o_arr_clear}, {31'd0, m_active && m_k == 1});
      chk("size_err", {31'd0, bus.o_size_err}, {31'd0, m_serr});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("west_%0d", i), {16'd0, west_v[i]}, {16'd0, exp_west(i)});
        chk($sformatf("north_%0d", i), {16'd0, north_v[i]}, {16'd0, exp_north(i)});
      end
`ifdef SEQ_JOB_CNT_EN
      chk("job_cnt", {16'd0, bus.o_job_cnt}, {16'd0, m_jc});
`endif
    end
  end

  // ---------------- array model driven by DUT outputs ----------------
  logic [31:0] pe_acc [4][4];
  logic [15:0] pe_a [4][4];
  logic [15:0] pe_b [4][4];
  logic [31:0] res [4][4];

  function automatic logic [15:0] a_in(int r, int c);
    if (c == 0) return west_v[r];
    return pe_a[r][c - 1];
  endfunction

  function automatic logic [15:0] b_in(int r, int c);
    if (r == 0) return north_v[c];
    return pe_b[r - 1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (bus.o_arr_clear) begin
          pe_acc[r][c] <= 32'd0;
          pe_a[r][c]   <= 16'd0;
          pe_b[r][c]   <= 16'd0;
        end else begin
          pe_acc[r][c] <= pe_acc[r][c] + 32'(a_in(r, c)) * 32'(b_in(r, c));
          pe_a[r][c]   <= a_in(r, c);
          pe_b[r][c]   <= b_in(r, c);
        end
        if (bus.o_capture) res[r][c] <= pe_acc[r][c];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input logic [15:0] d);
    bus.i_load_valid = 1'b1;
    bus.i_load_sel   = sel;
    bus.i_load_addr  = 4'(addr);
    bus.i_load_data  = d;
    tick();
    bus.i_load_valid = 1'b0;
  endtask

  task automatic start_job(input logic [2:0] sz, output int s0);
    bus.i_start = 1'b1;
    bus.i_size  = sz;
    s0 = cyc;
    tick();
    bus.i_start      = 1'b0;
    bus.i_load_valid = 1'b0;
  endtask

  task automatic wait_done(input int s0, input int span, output int dcyc, output int npulse);
    dcyc   = -1;
    npulse = 0;
    while (cyc < s0 + span) begin
      @(negedge clk);
      if (bus.o_done) begin
        if (npulse == 0) dcyc = cyc - s0;
        npulse++;
      end
    end
    tick();
  endtask

  task automatic chk_res(input string name, input int sz, input int val_in);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_pe%0d%0d", name, r, c), res[r][c],
            (r < sz && c < sz) ? 32'(val_in) : 32'd0);
      end
    end
  endtask

  int s0;
  int dcyc;
  int np;

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_a[i] = 16'd0;
      m_b[i] = 16'd0;
    end
    bus.i_load_valid = 1'b0;
    bus.i_load_sel   = 1'b0;
    bus.i_load_addr  = 4'd0;
    bus.i_load_data  = 16'd0;
    bus.i_start      = 1'b0;
    bus.i_size       = 3'd0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_west0", {16'd0, bus.o_west_0}, 32'd0);
    rst = 1'b0;
    tick();

    // identity A, ramp B; last B entry written together with start
    for (int i = 0; i < 16; i++) load(1'b0, i, (i / 4 == i % 4) ? 16'd1 : 16'd0);
    for (int i = 0; i < 15; i++) load(1'b1, i, 16'(i + 1));
    bus.i_load_valid = 1'b1;
    bus.i_load_sel   = 1'b1;
    bus.i_load_addr  = 4'd15;
    bus.i_load_data  = 16'd16;
    start_job(3'd4, s0);
    @(negedge clk);
    chk("id_c1_arr_clear", {31'd0, bus.o_arr_clear}, 32'd1);
    tick();
    @(negedge clk);
    chk("id_t0_west0", {16'd0, bus.o_west_0}, 32'd1);
    chk("id_t0_north0", {16'd0, bus.o_north_0}, 32'd1);
    chk("id_t0_west1", {16'd0, bus.o_west_1}, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("id_t3_north3", {16'd0, bus.o_north_3}, 32'd4);
    chk("id_t3_west3", {16'd0, bus.o_west_3}, 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("id_t6_west3", {16'd0, bus.o_west_3}, 32'd1);
    chk("id_t6_north3", {16'd0, bus.o_north_3}, 32'd16);
    wait_done(s0, 18, dcyc, np);
    chk("id_done_cycle", dcyc, 32'd13);
    chk("id_done_pulses", np, 32'd1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("id_pe%0d%0d", r, c), res[r][c], 32'(r * 4 + c + 1));

    // partial size 2 with A=2, B=3
    for (int i = 0; i < 16; i++) load(1'b0, i, 16'd2);
    for (int i = 0; i < 16; i++) load(1'b1, i, 16'd3);
    start_job(3'd2, s0);
    wait_done(s0, 12, dcyc, np);
    chk("p2_done_cycle", dcyc, 32'd7);
    chk("p2_done_pulses", np, 32'd1);
    chk_res("p2", 2, 12);

    // invalid sizes
    start_job(3'd0, s0);
    @(negedge clk);
    chk("inv0_size_err", {31'd0, bus.o_size_err}, 32'd1);
    chk("inv0_busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    @(negedge clk);
    chk("inv0_size_err_gone", {31'd0, bus.o_size_err}, 32'd0);
    tick();
    start_job(3'd5, s0);
    @(negedge clk);
    chk("inv5_size_err", {31'd0, bus.o_size_err}, 32'd1);
    chk("inv5_arr_clear", {31'd0, bus.o_arr_clear}, 32'd0);
    tick();

    // busy protection: load and start during FEED are ignored
    start_job(3'd4, s0);
    tick();
    tick();
    bus.i_load_valid = 1'b1;
    bus.i_load_sel   = 1'b0;
    bus.i_load_addr  = 4'd0;
    bus.i_load_data  = 16'hFFFF;
    bus.i_start      = 1'b1;
    bus.i_size       = 3'd4;
    tick();
    bus.i_load_valid = 1'b0;
    bus.i_start      = 1'b0;
    wait_done(s0, 24, dcyc, np);
    chk("bp_done_cycle", dcyc, 32'd13);
    chk("bp_done_pulses", np, 32'd1);
    chk_res("bp", 4, 24);
    start_job(3'd4, s0);
    wait_done(s0, 18, dcyc, np);
    chk("bp_rerun_done_cycle", dcyc, 32'd13);
    chk_res("bp_rerun", 4, 24);

    // reset during FEED t=2
    start_job(3'd4, s0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_west%0d", i), {16'd0, west_v[i]}, 32'd0);
      chk($sformatf("abort_north%0d", i), {16'd0, north_v[i]}, 32'd0);
    end
    wait_done(s0, 20, dcyc, np);
    chk("abort_no_done", np, 32'd0);
    start_job(3'd4, s0);
    wait_done(s0, 18, dcyc, np);
    chk("after_abort_done_cycle", dcyc, 32'd13);
    chk_res("after_abort", 4, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
